universal_shift_register: RTL and testbench
===========================================

// Module: universal_shift_register
// PURPOSE
//  Parametrised successor to our plain n-bit register: a WIDTH-bit register
//  with direct per-cycle modes (hold/load/shift/rotate/arith-shift/clear) and a
//  counted burst-shift engine (start/busy/done). Serves datapath word
//  alignment and serialisers. One clock; reset is synchronous, active-low.
// PARAMETERS
//  WIDTH  16  register width in bits (>=2)
//  CNT_W  5   width of burst shift-count input (max burst 2**CNT_W-1 cycles)
// PORTS
//  clk    in   1      rising-edge clock
//  rst_n  in   1      synchronous active-low reset, sampled on rising clk
//  en     in   1      direct-op enable (ignored while busy)
//  mode   in   3      operation select (table below)
//  in     in   WIDTH  parallel load data
//  sin_l  in   1      serial fill bit entering MSB (SHR)
//  sin_r  in   1      serial fill bit entering LSB (SHL)
//  start  in   1      request burst of cnt repetitions of mode
//  cnt    in   CNT_W  burst repetition count
//  out    out  WIDTH  register contents
//  sout_l out  1      = out[WIDTH-1]; combinational from register
//  sout_r out  1      = out[0]; combinational from register
//  busy   out  1      burst in progress
//  done   out  1      one-cycle pulse after final burst step
// BEHAVIOUR
//  Reset (rst_n=0 at edge): out=0, busy=0, done=0, FSM->IDLE, remaining=0.
//    Overrides everything, including a burst in flight.
//  Modes: 000 HOLD; 001 LOAD out<=in; 010 SHL {out[W-2:0],sin_r};
//    011 SHR {sin_l,out[W-1:1]}; 100 ROL {out[W-2:0],out[W-1]};
//    101 ROR {out[0],out[W-1:1]}; 110 ASR {out[W-1],out[W-1:1]};
//    111 CLEAR out<=0.
//  Priority per edge: reset > RUN step > start accept > en direct op > hold.
//  Direct op: IDLE, start=0 (or not honoured), en=1 -> mode applied at that
//    edge; latency 1 cycle. en=0 -> hold.
//  Burst-capable modes: 010..110 only. start with other modes is ignored and
//    falls through to the en direct op.
//  FSM states IDLE, RUN. Registered: op latched from mode, remaining count.
//  IDLE, start=1, burst mode, cnt=0: no shift; done=1 next cycle; stay IDLE.
//  IDLE, start=1, burst mode, cnt=1: shift #1 at accept edge; done=1 next
//    cycle; stay IDLE; busy stays 0.
//  IDLE, start=1, burst mode, cnt>=2: shift #1 at accept edge, remaining=cnt-1,
//    busy=1, ->RUN.
//  RUN: each edge applies latched op, remaining-=1; at the edge applying the
//    last step: busy<=0, done<=1, ->IDLE. Shifts occur at edges k..k+cnt-1;
//    done high exactly the cycle after edge k+cnt-1.
//  During RUN: en, mode, start, cnt, in ignored; sin_l/sin_r sampled live
//    each step.
//  done is a registered single-cycle pulse; never high together with busy.
//  Back-to-back: start may be accepted in the cycle done=1 (FSM is IDLE).
//  cnt>WIDTH legal: SHL/SHR fully flush, ROL/ROR wrap modulo WIDTH,
//    ASR saturates to all sign bits.
// TESTING (bench at WIDTH=16, clk period 20)
//  1 rst_n=0 one edge mid-activity -> out=0,busy=0,done=0 next cycle.
//  2 en=1 LOAD in=2000, then SHL sin_r=0 -> out=2000 then 4000; en=0 -> hold.
//  3 LOAD 16'h8001, en ROR one edge -> 16'hC000; ROL -> 16'h8001 back.
//  4 LOAD 16'h8000, start ASR cnt=3 -> out 16'hC000,E000,F000 on successive
//    edges; busy=1 two cycles; done=1 cycle after 3rd step; en/mode ignored.
//  5 start SHL cnt=0 -> out unchanged, done pulse, busy never 1; start with
//    LOAD mode + en=1 -> plain load, no done.
//  6 start ROL cnt=20 on 16'h0001, rst_n=0 after 5 steps -> out=0, busy=0,
//    no done; also ROL cnt=16 with no reset -> 16'h0001 at done.

Source files
------------

// File: rtl/universal_shift_register.sv
// universal_shift_register
//   WIDTH-bit register with per-cycle direct operations (hold, load, shift,
//   rotate, arithmetic shift, clear) and a counted burst engine that repeats
//   one shift/rotate mode cnt times.
// Ports:
//   clk, rst_n      rising-edge clock; synchronous active-low reset
//   en, mode, in    direct-op enable, operation select, parallel load data
//   sin_l, sin_r    serial fill bits entering MSB (SHR) / LSB (SHL)
//   start, cnt      burst request and repetition count
//   out             register contents
//   sout_l, sout_r  MSB / LSB of out
//   busy, done      burst in progress / one-cycle pulse after the final step
module universal_shift_register #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] out,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] ModeHold  = 3'b000;
  localparam logic [2:0] ModeLoad  = 3'b001;
  localparam logic [2:0] ModeShl   = 3'b010;
  localparam logic [2:0] ModeShr   = 3'b011;
  localparam logic [2:0] ModeRol   = 3'b100;
  localparam logic [2:0] ModeRor   = 3'b101;
  localparam logic [2:0] ModeAsr   = 3'b110;
  localparam logic [2:0] ModeClear = 3'b111;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] ld,
                                                input logic             sl,
                                                input logic             sr);
    logic [WIDTH-1:0] r;
    case (op)
      ModeHold:  r = v;
      ModeLoad:  r = ld;
      ModeShl:   r = {v[WIDTH-2:0], sr};
      ModeShr:   r = {sl, v[WIDTH-1:1]};
      ModeRol:   r = {v[WIDTH-2:0], v[WIDTH-1]};
      ModeRor:   r = {v[0], v[WIDTH-1:1]};
      ModeAsr:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      ModeClear: r = '0;
      default:   r = v;
    endcase
    return r;
  endfunction

  // Only the pure shift/rotate modes can be repeated by the burst engine.
  logic burst_mode;
  assign burst_mode = (mode >= ModeShl) && (mode <= ModeAsr);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StRun: begin
        // Serial fill bits are sampled live on every burst step.
        out_d = apply_op(op_q, out_q, in, sin_l, sin_r);
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (start && burst_mode) begin
          if (cnt == '0) begin
            done_d = 1'b1;
          end else begin
            // First step happens at the accept edge itself.
            out_d = apply_op(mode, out_q, in, sin_l, sin_r);
            if (cnt == CNT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              op_d    = mode;
              rem_d   = cnt - CNT_W'(1);
              busy_d  = 1'b1;
              state_d = StRun;
            end
          end
        end else if (en) begin
          out_d = apply_op(mode, out_q, in, sin_l, sin_r);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= ModeHold;
      rem_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out    = out_q;
  assign sout_l = out_q[WIDTH-1];
  assign sout_r = out_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register (WIDTH=16): directed scenarios plus
// randomized traffic, each cycle compared against an arithmetic reference.
module tb_universal_shift_register;

  localparam int W = 16;
  localparam int C = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] in;
  logic         sin_l;
  logic         sin_r;
  logic         start;
  logic [C-1:0] cnt;
  logic [W-1:0] out;
  logic         sout_l;
  logic         sout_r;
  logic         busy;
  logic         done;

  universal_shift_register #(.WIDTH(W), .CNT_W(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .in    (in),
    .sin_l (sin_l),
    .sin_r (sin_r),
    .start (start),
    .cnt   (cnt),
    .out   (out),
    .sout_l(sout_l),
    .sout_r(sout_r),
    .busy  (busy),
    .done  (done)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: register value as a plain integer and the number of
  // burst steps still owed after the current edge.
  int m_out  = 0;
  int m_left = 0;
  int m_op   = 0;
  int m_busy = 0;
  int m_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
  endtask

  function automatic int ref_op(input int op, input int v, input int ld, input int sl,
                                input int sr);
    case (op)
      0: return v;
      1: return ld;
      2: return (v * 2 + sr) % 65536;
      3: return v / 2 + sl * 32768;
      4: return (v * 2) % 65536 + v / 32768;
      5: return v / 2 + (v % 2) * 32768;
      6: return v / 2 + ((v >= 32768) ? 32768 : 0);
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int nd = 0;
    if (!rst_n) begin
      m_out = 0; m_left = 0; m_busy = 0; m_done = 0;
      return;
    end
    if (m_left > 0) begin
      m_out = ref_op(m_op, m_out, int'(in), int'(sin_l), int'(sin_r));
      m_left--;
      if (m_left == 0) begin m_busy = 0; nd = 1; end
    end else if (start && mode >= 2 && mode <= 6) begin
      if (cnt == 0) nd = 1;
      else begin
        m_out = ref_op(int'(mode), m_out, int'(in), int'(sin_l), int'(sin_r));
        if (cnt == 1) nd = 1;
        else begin m_left = int'(cnt) - 1; m_busy = 1; m_op = int'(mode); end
      end
    end else if (en) begin
      m_out = ref_op(int'(mode), m_out, int'(in), int'(sin_l), int'(sin_r));
    end
    m_done = nd;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("out", 32'(out), 32'(m_out));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("sout_l", 32'(sout_l), 32'(m_out / 32768));
    check("sout_r", 32'(sout_r), 32'(m_out % 2));
  endtask

  task automatic set(input logic e, input logic [2:0] m, input logic [W-1:0] d,
                     input logic s, input logic [C-1:0] c);
    en = e; mode = m; in = d; start = s; cnt = c;
  endtask

  int busy_seen;

  initial begin
    rst_n = 1'b0; sin_l = 1'b0; sin_r = 1'b0;
    set(1'b0, 3'd0, '0, 1'b0, '0);
    tick();
    tick();
    check("reset_out", 32'(out), 32'd0);
    rst_n = 1'b1;

    // 1: reset in the middle of a burst
    set(1'b1, 3'd1, 16'hA5A5, 1'b0, '0); tick();
    set(1'b0, 3'd4, '0, 1'b1, 5'd10);    tick();
    start = 1'b0; tick(); tick();
    rst_n = 1'b0; tick();
    check("t1_out", 32'(out), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // 2: load, shift left, hold
    set(1'b1, 3'd1, 16'd2000, 1'b0, '0); tick();
    check("t2_load", 32'(out), 32'd2000);
    mode = 3'd2; sin_r = 1'b0; tick();
    check("t2_shl", 32'(out), 32'd4000);
    en = 1'b0; tick();
    check("t2_hold", 32'(out), 32'd4000);

    // 3: rotate right then left
    set(1'b1, 3'd1, 16'h8001, 1'b0, '0); tick();
    mode = 3'd5; tick();
    check("t3_ror", 32'(out), 32'h0000C000);
    mode = 3'd4; tick();
    check("t3_rol", 32'(out), 32'h00008001);

    // 4: ASR burst of 3; direct-op inputs ignored while running
    set(1'b1, 3'd1, 16'h8000, 1'b0, '0); tick();
    set(1'b0, 3'd6, '0, 1'b1, 5'd3); tick();
    check("t4_s1", 32'(out), 32'h0000C000);
    check("t4_b1", 32'(busy), 32'd1);
    set(1'b1, 3'd1, 16'h1234, 1'b0, 5'd7); tick();
    check("t4_s2", 32'(out), 32'h0000E000);
    check("t4_b2", 32'(busy), 32'd1);
    tick();
    check("t4_s3", 32'(out), 32'h0000F000);
    check("t4_b3", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd1);
    en = 1'b0; tick();
    check("t4_done_low", 32'(done), 32'd0);

    // 5: zero-count burst, and start with a non-burst mode
    set(1'b0, 3'd2, '0, 1'b1, 5'd0); tick();
    check("t5_out", 32'(out), 32'h0000F000);
    check("t5_done", 32'(done), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    set(1'b1, 3'd1, 16'h1234, 1'b1, 5'd4); tick();
    check("t5_load", 32'(out), 32'h00001234);
    check("t5_nodone", 32'(done), 32'd0);

    // 6: long ROL burst cut by reset, then a full 16-step rotation
    set(1'b1, 3'd1, 16'h0001, 1'b0, '0); tick();
    set(1'b0, 3'd4, '0, 1'b1, 5'd20); tick();
    start = 1'b0;
    repeat (4) tick();
    check("t6_mid", 32'(out), 32'h00000020);
    rst_n = 1'b0; tick();
    check("t6_rst_out", 32'(out), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; tick();
    check("t6_nodone", 32'(done), 32'd0);
    set(1'b1, 3'd1, 16'h0001, 1'b0, '0); tick();
    set(1'b0, 3'd4, '0, 1'b1, 5'd16); tick();
    start = 1'b0;
    busy_seen = 0;
    repeat (15) begin tick(); busy_seen += int'(busy); end
    check("t6_wrap", 32'(out), 32'h00000001);
    check("t6_done", 32'(done), 32'd1);
    check("t6_busy_cycles", 32'(busy_seen), 32'd14);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      en    = 1'($urandom);
      mode  = 3'($urandom);
      in    = 16'($urandom);
      sin_l = 1'($urandom);
      sin_r = 1'($urandom);
      start = ($urandom_range(0, 3) == 0);
      cnt   = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
